// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data-memory port: RV32I load/store funct3
// codes, the port FSM state type, byte-enable patterns and request decode helpers.
package lsu_pkg;

  localparam logic [2:0] FUNC_LB  = 3'b000;
  localparam logic [2:0] FUNC_LH  = 3'b001;
  localparam logic [2:0] FUNC_LW  = 3'b010;
  localparam logic [2:0] FUNC_LBU = 3'b100;
  localparam logic [2:0] FUNC_LHU = 3'b101;
  localparam logic [2:0] FUNC_SB  = 3'b000;
  localparam logic [2:0] FUNC_SH  = 3'b001;
  localparam logic [2:0] FUNC_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // A request must be exactly one of load/store and carry a funct3 that kind supports.
  function automatic logic is_illegal(input logic load, input logic store,
                                      input logic [2:0] f3);
    if (load == store) return 1'b1;
    if (load) return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    return !((f3 == FUNC_SB) || (f3 == FUNC_SH) || (f3 == FUNC_SW));
  endfunction

  // Low two funct3 bits give the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

  // Halfwords only look at a[1] and words ignore a, so unaligned addresses snap down.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      FUNC_SB: return BE_BYTE << a;
      FUNC_SH: return a[1] ? BE_HALF_HI : BE_HALF_LO;
      default: return BE_WORD;
    endcase
  endfunction

  // Replicating the store data lets the memory pick whichever lane the enables select.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      FUNC_SB: return {4{d[7:0]}};
      FUNC_SH: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem_port_if.sv
// Request/response handshake and word-addressed memory bus of the LSU data port.
interface lsu_dmem_port_if #(parameter int ADDR_W = 5);

  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Moves the addressed byte/halfword of a memory word down to bit 0 and
// sign- or zero-extends it according to the RV32I load funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extension; funct3[2] marks the unsigned variants.
  always_comb begin
    byte_sel = 8'(word >> {addr_lo, 3'b000});
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      FUNC_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      FUNC_LBU: result = {24'h0, byte_sel};
      FUNC_LH:  result = {{16{half_sel[15]}}, half_sel};
      FUNC_LHU: result = {16'h0, half_sel};
      default:  result = word;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_port.sv
// LSU data-memory port: accepts one load/store at a time, runs a single bus
// transaction with byte enables and a bus timeout, and returns extended load data.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with
// resp_err instead of silently aligning them down.
module lsu_dmem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input logic            clk,
  input logic            rst_n,
  lsu_dmem_port_if.slave io
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  lsu_state_e        state_q, state_d;
  logic              load_q, load_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              trap;
  logic [31:0]       load_result;

  lsu_load_align u_align (
    .word    (io.bus_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .result  (load_result)
  );

  // Requests that never reach the bus: bad encodings, and misalignment when trapping.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    trap = is_illegal(io.req_load, io.req_store, io.req_funct3) ||
           is_misaligned(io.req_funct3, io.req_addr[1:0]);
`else
    trap = is_illegal(io.req_load, io.req_store, io.req_funct3);
`endif
  end

  // State and latched request registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      cnt_q    <= 16'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, wait for ack or timeout in BUS, one-cycle RESP.
  always_comb begin
    state_d  = state_q;
    load_d   = load_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (io.req_valid) begin
          load_d   = io.req_load;
          store_d  = io.req_store;
          funct3_d = io.req_funct3;
          addr_d   = io.req_addr[ADDR_W+1:0];
          wdata_d  = io.req_wdata;
          cnt_d    = 16'h0;
          rdata_d  = 32'h0;
          err_d    = trap;
          state_d  = trap ? RESP : BUS;
        end
      end
      BUS: begin
        cnt_d = cnt_q + 16'h1;
        if (io.bus_ack) begin
          rdata_d = load_q ? load_result : 32'h0;
          state_d = RESP;
        end else if ((TIMEOUT_CYC > 0) && (cnt_q == TO_LAST)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state so everything except req_ready is 0 outside its phase.
  always_comb begin
    io.req_ready  = (state_q == IDLE);
    io.resp_valid = (state_q == RESP);
    io.resp_rdata = 32'h0;
    io.resp_err   = 1'b0;
    io.bus_req    = 1'b0;
    io.bus_we     = 1'b0;
    io.bus_addr   = '0;
    io.bus_be     = 4'b0000;
    io.bus_wdata  = 32'h0;
    if (state_q == RESP) begin
      io.resp_rdata = rdata_q;
      io.resp_err   = err_q;
    end
    if (state_q == BUS) begin
      io.bus_req  = 1'b1;
      io.bus_we   = store_q;
      io.bus_addr = addr_q[ADDR_W+1:2];
      if (store_q) begin
        io.bus_be    = store_be(funct3_q, addr_q[1:0]);
        io.bus_wdata = store_lanes(funct3_q, wdata_q);
      end else begin
        io.bus_be = BE_WORD;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Testbench for lsu_dmem_port: each scenario task drives requests and bus
// acks, checking bus-side signals inline; expected responses are queued and
// compared by a monitor whenever resp_valid fires.
module tb_lsu_dmem_port;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] word;
    logic [31:0] exp;
    logic [4:0]  baddr;
  } load_vec_t;

  logic  clk;
  logic  rst_n;
  int    tests_run;
  int    tests_failed;
  resp_t exp_q[$];
  resp_t mon_exp;

  lsu_dmem_port_if #(.ADDR_W(5)) dif ();

  lsu_dmem_port #(.ADDR_W(5), .TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (dif)
  );

  // Free-running clock, rising edges at 5, 15, 25 ns ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: every response pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dif.resp_valid === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_resp: got resp_valid=1 with nothing pending, expected none");
      end else begin
        mon_exp = exp_q.pop_front();
        if ({dif.resp_err, dif.resp_rdata} !== {mon_exp.err, mon_exp.rdata}) begin
          tests_failed++;
          $display("[TB] FAIL resp: got err=%b rdata=%h, expected err=%b rdata=%h",
                   dif.resp_err, dif.resp_rdata, mon_exp.err, mon_exp.rdata);
        end
      end
    end
  end

  // Global safety net so the run can never hang.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single cycle; returns 1 ns after the accepting edge.
  task automatic send_req(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d);
    dif.req_valid  = 1'b1;
    dif.req_load   = ld;
    dif.req_store  = st;
    dif.req_funct3 = f3;
    dif.req_addr   = a;
    dif.req_wdata  = d;
    @(posedge clk);
    #1;
    dif.req_valid  = 1'b0;
    dif.req_load   = 1'b0;
    dif.req_store  = 1'b0;
    dif.req_funct3 = 3'b000;
    dif.req_addr   = 32'h0;
    dif.req_wdata  = 32'h0;
  endtask

  // Acks at the current bus cycle with the given read word, then lands in RESP.
  task automatic ack_now(input logic [31:0] rd);
    dif.bus_ack   = 1'b1;
    dif.bus_rdata = rd;
    @(posedge clk);
    #1;
    dif.bus_ack   = 1'b0;
    dif.bus_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests_run++;
    if (dif.req_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b, expected 1", dif.req_ready);
    end
    tests_run++;
    if ({dif.bus_req, dif.bus_we, dif.bus_addr, dif.bus_be, dif.bus_wdata,
         dif.resp_valid, dif.resp_err, dif.resp_rdata} !== 76'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got bus_req=%b be=%b resp_valid=%b, expected all 0",
               dif.bus_req, dif.bus_be, dif.resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sync();
  endtask

  task automatic test_store_byte();
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    send_req(1'b0, 1'b1, 3'b000, 32'h0000_0006, 32'h0000_00A5);
    @(negedge clk);
    tests_run++;
    if ({dif.bus_req, dif.bus_we, dif.bus_addr, dif.bus_be, dif.bus_wdata} !==
        {1'b1, 1'b1, 5'd1, 4'b0100, 32'hA5A5_A5A5}) begin
      tests_failed++;
      $display("[TB] FAIL sb_bus: got req=%b we=%b addr=%0d be=%b wdata=%h, expected 1 1 1 0100 a5a5a5a5",
               dif.bus_req, dif.bus_we, dif.bus_addr, dif.bus_be, dif.bus_wdata);
    end
    ack_now(32'h0);
    @(negedge clk);
    tests_run++;
    if ({dif.resp_valid, dif.req_ready} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL sb_latency: got resp_valid=%b req_ready=%b, expected 1 0",
               dif.resp_valid, dif.req_ready);
    end
    sync();
  endtask

  task automatic test_store_half();
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    send_req(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h1234_ABCD);
    @(negedge clk);
    tests_run++;
    if ({dif.bus_we, dif.bus_addr, dif.bus_be, dif.bus_wdata} !==
        {1'b1, 5'd4, 4'b1100, 32'hABCD_ABCD}) begin
      tests_failed++;
      $display("[TB] FAIL sh_bus: got we=%b addr=%0d be=%b wdata=%h, expected 1 4 1100 abcdabcd",
               dif.bus_we, dif.bus_addr, dif.bus_be, dif.bus_wdata);
    end
    ack_now(32'hFFFF_FFFF);
    sync();
  endtask

  task automatic test_loads();
    load_vec_t lv[$];
    lv.push_back('{f3: 3'b001, addr: 32'h0A, word: 32'h8001_1234, exp: 32'hFFFF_8001, baddr: 5'd2});
    lv.push_back('{f3: 3'b101, addr: 32'h0A, word: 32'h8001_1234, exp: 32'h0000_8001, baddr: 5'd2});
    lv.push_back('{f3: 3'b000, addr: 32'h09, word: 32'h8001_1234, exp: 32'h0000_0012, baddr: 5'd2});
    lv.push_back('{f3: 3'b000, addr: 32'h0B, word: 32'h8001_1234, exp: 32'hFFFF_FF80, baddr: 5'd2});
    lv.push_back('{f3: 3'b100, addr: 32'h0B, word: 32'h8001_1234, exp: 32'h0000_0080, baddr: 5'd2});
    lv.push_back('{f3: 3'b001, addr: 32'h1C, word: 32'h0000_7FFE, exp: 32'h0000_7FFE, baddr: 5'd7});
    lv.push_back('{f3: 3'b010, addr: 32'h0000_0084, word: 32'h8001_1234, exp: 32'h8001_1234, baddr: 5'd1});
    foreach (lv[i]) begin
      exp_q.push_back('{rdata: lv[i].exp, err: 1'b0});
      send_req(1'b1, 1'b0, lv[i].f3, lv[i].addr, 32'hFFFF_FFFF);
      @(negedge clk);
      tests_run++;
      if ({dif.bus_req, dif.bus_we, dif.bus_addr, dif.bus_be} !== {1'b1, 1'b0, lv[i].baddr, 4'b1111}) begin
        tests_failed++;
        $display("[TB] FAIL load_bus[%0d]: got req=%b we=%b addr=%0d be=%b, expected 1 0 %0d 1111",
                 i, dif.bus_req, dif.bus_we, dif.bus_addr, dif.bus_be, lv[i].baddr);
      end
      ack_now(lv[i].word);
      sync();
    end
  endtask

  task automatic test_misaligned();
`ifdef LSU_MISALIGN_TRAP_EN
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    send_req(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
    @(negedge clk);
    tests_run++;
    if ({dif.bus_req, dif.resp_valid} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL lw_misaligned_trap: got bus_req=%b resp_valid=%b, expected 0 1",
               dif.bus_req, dif.resp_valid);
    end
    sync();
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    send_req(1'b0, 1'b1, 3'b001, 32'h0000_0003, 32'h1234_5678);
    @(negedge clk);
    tests_run++;
    if ({dif.bus_req, dif.resp_valid} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL sh_misaligned_trap: got bus_req=%b resp_valid=%b, expected 0 1",
               dif.bus_req, dif.resp_valid);
    end
    sync();
`else
    exp_q.push_back('{rdata: 32'h1357_9BDF, err: 1'b0});
    send_req(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
    @(negedge clk);
    tests_run++;
    if ({dif.bus_req, dif.bus_addr, dif.bus_be} !== {1'b1, 5'd1, 4'b1111}) begin
      tests_failed++;
      $display("[TB] FAIL lw_misaligned_bus: got req=%b addr=%0d be=%b, expected 1 1 1111",
               dif.bus_req, dif.bus_addr, dif.bus_be);
    end
    ack_now(32'h1357_9BDF);
    sync();
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    send_req(1'b0, 1'b1, 3'b001, 32'h0000_0003, 32'h1234_5678);
    @(negedge clk);
    tests_run++;
    if ({dif.bus_req, dif.bus_be, dif.bus_wdata} !== {1'b1, 4'b1100, 32'h5678_5678}) begin
      tests_failed++;
      $display("[TB] FAIL sh_misaligned_bus: got req=%b be=%b wdata=%h, expected 1 1100 56785678",
               dif.bus_req, dif.bus_be, dif.bus_wdata);
    end
    ack_now(32'h0);
    sync();
`endif
  endtask

  task automatic test_illegal();
    logic [4:0] ill[$];
    ill.push_back({1'b0, 1'b1, 3'b011});
    ill.push_back({1'b1, 1'b1, 3'b010});
    ill.push_back({1'b0, 1'b0, 3'b000});
    ill.push_back({1'b1, 1'b0, 3'b110});
    foreach (ill[i]) begin
      exp_q.push_back('{rdata: 32'h0, err: 1'b1});
      send_req(ill[i][4], ill[i][3], ill[i][2:0], 32'h0000_0008, 32'h1111_1111);
      @(negedge clk);
      tests_run++;
      if ({dif.bus_req, dif.resp_valid} !== 2'b01) begin
        tests_failed++;
        $display("[TB] FAIL illegal[%0d]: got bus_req=%b resp_valid=%b, expected 0 1",
                 i, dif.bus_req, dif.resp_valid);
      end
      sync();
    end
  endtask

  task automatic test_timeout();
    int high_cycles;
    high_cycles = 0;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    send_req(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 40 && dif.bus_req === 1'b1; i++) begin
      high_cycles++;
      @(negedge clk);
    end
    tests_run++;
    if (high_cycles != 16) begin
      tests_failed++;
      $display("[TB] FAIL timeout_len: got bus_req high %0d cycles, expected 16", high_cycles);
    end
    tests_run++;
    if (dif.resp_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_resp: got resp_valid=%b, expected 1", dif.resp_valid);
    end
    dif.bus_ack   = 1'b1;
    dif.bus_rdata = 32'hBAD0_BAD0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({dif.bus_req, dif.resp_valid, dif.req_ready} !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL late_ack: got bus_req=%b resp_valid=%b req_ready=%b, expected 0 0 1",
               dif.bus_req, dif.resp_valid, dif.req_ready);
    end
    dif.bus_ack   = 1'b0;
    dif.bus_rdata = 32'h0;
    sync();
  endtask

  task automatic test_reset_mid();
    send_req(1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'h0);
    @(negedge clk);
    tests_run++;
    if (dif.bus_req !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_bus_req: got %b, expected 1", dif.bus_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({dif.bus_req, dif.req_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got bus_req=%b req_ready=%b, expected 0 1",
               dif.bus_req, dif.req_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({dif.resp_valid, dif.req_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL after_reset: got resp_valid=%b req_ready=%b, expected 0 1",
               dif.resp_valid, dif.req_ready);
    end
    sync();
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    send_req(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    tests_run++;
    if ({dif.bus_we, dif.bus_addr, dif.bus_be, dif.bus_wdata} !==
        {1'b1, 5'd4, 4'b1111, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("[TB] FAIL sw_after_reset: got we=%b addr=%0d be=%b wdata=%h, expected 1 4 1111 deadbeef",
               dif.bus_we, dif.bus_addr, dif.bus_be, dif.bus_wdata);
    end
    ack_now(32'h0);
    sync();
  endtask

  // Scenario sequence followed by the final scoreboard drain check.
  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    dif.req_valid  = 1'b0;
    dif.req_load   = 1'b0;
    dif.req_store  = 1'b0;
    dif.req_funct3 = 3'b000;
    dif.req_addr   = 32'h0;
    dif.req_wdata  = 32'h0;
    dif.bus_ack    = 1'b0;
    dif.bus_rdata  = 32'h0;
    test_reset();
    test_store_byte();
    test_store_half();
    test_loads();
    test_misaligned();
    test_illegal();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_port.md
Name: lsu_dmem_port

Overview:
- Data-memory responder side of the ALU memory path: accepts load/store requests (byte address, store data, funct3) and runs one transaction on a single-port word-addressed data memory bus.
- Generates byte enables and replicated store lanes, then returns aligned and sign/zero-extended load data.
- Sits between execute-stage ALU output (address = rs1+imm) and data memory.
- One outstanding request; per-request bus timeout.

Parameters:
ADDR_W, 5, word-address width on bus (bus_addr = req_addr[ADDR_W+1:2])
TIMEOUT_CYC, 16, max cycles bus_req held without bus_ack before error; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request strobe
req_ready  out  1  block idle, can accept
req_load  in  1  request is load
req_store  in  1  request is store
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  byte address
req_wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores/errors
resp_err  out  1  qualifies resp_valid: illegal, misaligned or timeout
bus_req  out  1  memory request, held until ack
bus_we  out  1  1=write
bus_addr  out  ADDR_W  word address
bus_be  out  4  byte enables, bit i = byte lane i
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  memory completion, may assert the same cycle as bus_req
bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset (async, rst_n=0) puts the block in IDLE. All outputs are 0 except req_ready=1. Reset mid-transaction drops bus_req immediately and discards the request; no resp_valid follows.
- FSM states: IDLE, BUS, RESP.
- IDLE
  - req_ready=1.
  - Handshake on req_valid&req_ready latches all req_* fields.
  - Legal, aligned request goes to BUS next cycle.
  - Illegal or trapped request goes straight to RESP with err=1; no bus cycle.
- Illegal request:
  - load and store both 1, or both 0;
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010}.
- BUS
  - bus_req=1; bus_we/addr/be/wdata stable from latched values.
  - Timeout counter increments each cycle.
  - On bus_ack: loads capture bus_rdata; go to RESP.
  - If TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC-1 without ack: drop bus_req, set err, go to RESP.
  - bus_ack is ignored outside BUS.
- RESP
  - resp_valid=1 for exactly one cycle, with resp_rdata and resp_err.
  - req_ready=0; return to IDLE.
- Latency: accept at cycle N, bus_req at N+1; ack at N+1 gives resp_valid at N+2. Back-to-back throughput is one request per 3 cycles minimum.
- Store lanes (a = addr[1:0]):
  - SB: be = 0001<<a, wdata = {4{d[7:0]}}.
  - SH: be = a[1] ? 1100 : 0011, wdata = {2{d[15:0]}}.
  - SW: be = 1111, wdata = d.
- Loads: bus_be=1111. The lane selected by a is shifted to bit 0, then extended:
  - LB: sign-extend byte.
  - LBU: zero-extend byte.
  - LH: sign-extend halfword.
  - LHU: zero-extend halfword.
  - LW: word unchanged.
- Misaligned: halfword with a[0]=1; word with a!=0. Handling depends on MISALIGN_TRAP_EN.
- Address bits above ADDR_W+1 are ignored (wrap within memory).

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned request returns resp_err=1, rdata=0, and no bus transaction occurs.
- Undefined: misalignment is not checked. Halfword uses a[1] only; word uses lane 0 (low address bits forced to alignment). The bus transaction proceeds and err reflects only illegal/timeout.

Decomposition:
- Package lsu_pkg:
  - funct3 constants FUNC_LB/LH/LW/LBU/LHU/SB/SH/SW;
  - FSM state enum (IDLE, BUS, RESP);
  - byte-enable patterns.
- Sub-module lsu_load_align (combinational): word, addr[1:0], funct3 -> extended 32-bit load result. It is instantiated once and tested standalone.

Test Plan:
- SB addr=0x0000_0006, wdata=0x0000_00A5, ack at first bus cycle -> bus_addr=1, be=0100, bus_wdata=0xA5A5A5A5, we=1; resp_valid 2 cycles after accept, err=0.
- LH addr=0x0A, bus_rdata=0x8001_1234 -> bus_addr=2, resp_rdata=0xFFFF_8001. LHU same -> 0x0000_8001. LB addr=0x09 -> 0x0000_0012.
- LW addr=0x06 with LSU_MISALIGN_TRAP_EN -> no bus_req, resp_err=1, rdata=0. Without the macro -> bus_addr=1, rdata=bus_rdata.
- Store with funct3=011, or load&store both set -> resp_err=1 one cycle after accept, bus_req never asserts.
- bus_ack held 0, TIMEOUT_CYC=16 -> bus_req high exactly 16 cycles, then resp_valid with err=1; a late bus_ack is ignored.
- rst_n asserted while bus_req=1 -> bus_req=0 asynchronously, req_ready=1 after release, no resp_valid; the next SW addr=0x10 data=0xDEADBEEF completes with be=1111, bus_addr=4.
